// File: rtl/aqalu.sv
// Registered 2-bit ALU: opcodes 0-14 are single-cycle functions, opcode 15 counts elapsed "seconds".
// Define AQALU_SAT_EN to make the seconds counter saturate at 255 instead of wrapping to 0.
module aqalu #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [3:0] Opcode,
    output logic [7:0] Output
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0] OP_SECONDS = 4'd15;

    logic [PW-1:0] prescaler;
    logic [7:0]    seconds;
    logic [7:0]    secondsNext;
    logic [7:0]    aluResult;
    logic [7:0]    a8;
    logic [7:0]    b8;

    assign a8 = {6'b0, A};
    assign b8 = {6'b0, B};

`ifdef AQALU_SAT_EN
    assign secondsNext = (seconds == 8'hFF) ? 8'hFF : seconds + 8'd1;
`else
    assign secondsNext = seconds + 8'd1;
`endif

    always_comb begin
        aluResult = 8'h00;
        case (Opcode)
            4'd0:  aluResult = a8 + b8;
            4'd1:  aluResult = a8 - b8;
            4'd2:  aluResult = a8 * b8;
            4'd3:  aluResult = (B == 2'd0) ? 8'hFF : a8 / b8;
            4'd4:  aluResult = (B == 2'd0) ? 8'hFF : a8 % b8;
            4'd5:  aluResult = {6'b0, A & B};
            4'd6:  aluResult = {6'b0, A | B};
            4'd7:  aluResult = {6'b0, A ^ B};
            4'd8:  aluResult = {6'b0, ~(A & B)};
            4'd9:  aluResult = {6'b0, ~(A | B)};
            4'd10: aluResult = {6'b0, ~(A ^ B)};
            4'd11: aluResult = {3'b0, A, B, 1'b0};
            4'd12: aluResult = {5'b0, A, B[1]};
            4'd13: aluResult = {5'b0, A > B, A == B, A < B};
            4'd14: begin
                // Exponent is at most 3, so an explicit table keeps this purely combinational.
                case (B)
                    2'd0:    aluResult = 8'd1;
                    2'd1:    aluResult = a8;
                    2'd2:    aluResult = a8 * a8;
                    default: aluResult = a8 * a8 * a8;
                endcase
            end
            default: aluResult = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            seconds   <= 8'h00;
            Output    <= 8'h00;
        end else if (Opcode != OP_SECONDS) begin
            // Any non-counter opcode discards the count so re-entry starts from zero.
            prescaler <= '0;
            seconds   <= 8'h00;
            Output    <= aluResult;
        end else if (prescaler == LAST_TICK) begin
            prescaler <= '0;
            seconds   <= secondsNext;
            Output    <= secondsNext;
        end else begin
            prescaler <= prescaler + PW'(1);
            Output    <= seconds;
        end
    end

endmodule

// File: tb/tb_aqalu.sv
// Self-checking bench for aqalu: directed cases plus randomized opcodes against a behavioural model.
module tb_aqalu;

    localparam int TPS = 10;

    logic       clock;
    logic       reset;
    logic [1:0] A;
    logic [1:0] B;
    logic [3:0] Opcode;
    logic [7:0] Output;

    int checks = 0;
    int errors = 0;
    int op15_edges = 0;
    logic [7:0] exp_q[$];

    aqalu #(.TICKS_PER_SEC(TPS)) dut (
        .clock(clock),
        .reset(reset),
        .A(A),
        .B(B),
        .Opcode(Opcode),
        .Output(Output)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:  r = a + b;
            1:  r = (a - b) & 255;
            2:  r = a * b;
            3:  r = (b == 0) ? 255 : a / b;
            4:  r = (b == 0) ? 255 : a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = (~(a & b)) & 3;
            9:  r = (~(a | b)) & 3;
            10: r = (~(a ^ b)) & 3;
            11: r = ((a * 4 + b) * 2) & 31;
            12: r = (a * 4 + b) / 2;
            13: r = (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
            14: r = a ** b;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [7:0] ref_seconds(input int edges);
        int s;
        s = edges / TPS;
`ifdef AQALU_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        return s[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: apply inputs away from the edge, clock once, then compare the model's prediction
    task automatic do_cycle(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                            input string tag);
        Opcode = op;
        A = a;
        B = b;
        if (op == 4'd15) begin
            op15_edges++;
            exp_q.push_back(ref_seconds(op15_edges));
        end else begin
            op15_edges = 0;
            exp_q.push_back(ref_alu(int'(op), int'(a), int'(b)));
        end
        @(posedge clock);
        #1;
        check(tag, Output, exp_q.pop_front());
    endtask

    task automatic run_op15(input int n, input string tag);
        for (int i = 0; i < n; i++)
            do_cycle(4'd15, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), tag);
    endtask

    initial begin
        reset = 1'b0;
        A = 2'd0;
        B = 2'd0;
        Opcode = 4'd0;
        #1;
        check("reset_t1", Output, 8'h00);
        Opcode = 4'd15;
        A = 2'd3;
        B = 2'd3;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_held", Output, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check("reset_release", Output, 8'h00);
        @(posedge clock);
        #1;

        // directed arithmetic
        do_cycle(4'd0, 2'd3, 2'd2, "add_3_2");
        check("add_const", Output, 8'd5);
        do_cycle(4'd1, 2'd3, 2'd2, "sub_3_2");
        do_cycle(4'd2, 2'd3, 2'd2, "mul_3_2");
        check("mul_const", Output, 8'd6);
        do_cycle(4'd3, 2'd3, 2'd2, "div_3_2");
        do_cycle(4'd4, 2'd3, 2'd2, "mod_3_2");
        do_cycle(4'd1, 2'd0, 2'd3, "sub_0_3");
        check("sub_neg_const", Output, 8'hFD);
        do_cycle(4'd3, 2'd2, 2'd0, "div_by0");
        check("div_by0_const", Output, 8'hFF);
        do_cycle(4'd4, 2'd2, 2'd0, "mod_by0");

        // directed logic/shift/compare/power with A=2,B=3
        for (int op = 5; op <= 14; op++)
            do_cycle(4'(op), 2'd2, 2'd3, $sformatf("op%0d_2_3", op));
        check("pow_const", Output, 8'h08);
        do_cycle(4'd14, 2'd0, 2'd0, "pow_0_0");
        do_cycle(4'd14, 2'd3, 2'd3, "pow_3_3");
        do_cycle(4'd13, 2'd3, 2'd1, "cmp_gt");
        do_cycle(4'd13, 2'd1, 2'd1, "cmp_eq");

        // counter: 0 until TPS edges, then increments
        run_op15(TPS - 1, "sec_first");
        check("sec_before_1", Output, 8'd0);
        run_op15(1, "sec_one");
        check("sec_at_1", Output, 8'd1);
        run_op15(2 * TPS, "sec_three");
        check("sec_at_3", Output, 8'd3);
        do_cycle(4'd0, 2'd1, 2'd1, "leave_op15");
        check("leave_const", Output, 8'd2);
        do_cycle(4'd15, 2'd0, 2'd0, "reenter_op15");
        check("reenter_const", Output, 8'd0);

        // wrap or saturate after 256 counted seconds
        run_op15(256 * TPS - 1, "sec_long");
        run_op15(3 * TPS, "sec_past_255");
        do_cycle(4'd7, 2'd1, 2'd3, "after_wrap_xor");

        // asynchronous reset mid-count
        run_op15(2 * TPS, "sec_pre_reset");
        check("sec_pre_reset_const", Output, 8'd2);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_reset", Output, 8'h00);
        #1;
        reset = 1'b1;
        op15_edges = 0;
        #1;
        run_op15(TPS + 2, "sec_after_reset");

        // randomized opcodes with occasional counter bursts
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                run_op15($urandom_range(1, 3 * TPS), "rand_op15");
            else
                do_cycle(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), "rand_alu");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
